// File: rtl/proj_div_pkg.sv
// Shared definitions for the divider sequencer: CSR map of the divider peripheral,
// FSM state encoding and result status codes.
package proj_div_pkg;

  localparam logic [31:0] ADDR_DVD   = 32'h3000_0000;
  localparam logic [31:0] ADDR_DVS   = 32'h3000_0004;
  localparam logic [31:0] ADDR_QUO   = 32'h3000_0008;
  localparam logic [31:0] ADDR_FINI  = 32'h3000_0014;
  localparam logic [31:0] ADDR_START = 32'h3000_0018;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_BAD_DVS = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    WR_DVD,
    WR_DVS,
    WR_START,
    GAP,
    RD_FINI,
    RD_QUO,
    PUSH
  } state_t;

  function automatic logic is_bus_state(input state_t s);
    return (s == WR_DVD) || (s == WR_DVS) || (s == WR_START) ||
           (s == RD_FINI) || (s == RD_QUO);
  endfunction

endpackage

// File: rtl/proj_div_op_fifo.sv
// Operand-pair FIFO with first-word fall-through output; a push and pop in the
// same cycle is accepted even when full, leaving the count unchanged.
module proj_div_op_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/proj_div_sequencer.sv
// Drives a Wishbone-attached divider: pops operand pairs, writes them, starts the
// unit, polls FINI with a bounded budget and returns quotient plus status.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid is never withdrawn and its payload never changes until then.
module proj_div_sequencer
  import proj_div_pkg::*;
#(
  parameter int WBW        = 32,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int POLL_LIMIT = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [XLEN-1:0]  op_dividend_i,
  input  logic [XLEN-1:0]  op_divisor_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [XLEN-1:0]  res_quotient_o,
  output logic [1:0]       res_status_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WBW/8-1:0] wbm_sel_o,
  output logic [WBW-1:0]   wbm_adr_o,
  output logic [WBW-1:0]   wbm_dat_o,
  input  logic [WBW-1:0]   wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output state_t           dbg_state_o
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [1:0]        status_q, status_d;
  logic [PCW-1:0]    poll_q, poll_d;
  logic              gap_cnt_q, gap_cnt_d;
  logic              acked_q;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_dout;
  logic              access;
  logic              ack;

  proj_div_op_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (op_valid_i && op_ready_o),
    .din_i   ({op_dividend_i, op_divisor_i}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign op_ready_o = !fifo_full;

  // acked_q blanks the strobe for the cycle after every ack, so accesses
  // never run back to back and the GAP dwell starts with the bus already idle.
  assign access    = is_bus_state(state_q) && !acked_q;
  assign ack       = access && wbm_ack_i;
  assign wbm_cyc_o = access;
  assign wbm_stb_o = access;

  always_comb begin
    wbm_we_o  = 1'b0;
    wbm_sel_o = '0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    if (access) begin
      wbm_sel_o = '1;
      unique case (state_q)
        WR_DVD: begin
          wbm_we_o  = 1'b1;
          wbm_adr_o = WBW'(ADDR_DVD);
          wbm_dat_o = WBW'(dvd_q);
        end
        WR_DVS: begin
          wbm_we_o  = 1'b1;
          wbm_adr_o = WBW'(ADDR_DVS);
          wbm_dat_o = WBW'(dvs_q);
        end
        WR_START: begin
          wbm_we_o  = 1'b1;
          wbm_adr_o = WBW'(ADDR_START);
        end
        RD_FINI:  wbm_adr_o = WBW'(ADDR_FINI);
        RD_QUO:   wbm_adr_o = WBW'(ADDR_QUO);
        default:  wbm_adr_o = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    status_d  = status_q;
    poll_d    = poll_q;
    gap_cnt_d = gap_cnt_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          {dvd_d, dvs_d} = fifo_dout;
          poll_d         = '0;
          state_d        = CHECK;
        end
      end
      CHECK: begin
        if (dvs_q < XLEN'(2)) begin
          quo_d    = '0;
          status_d = STATUS_BAD_DVS;
          state_d  = PUSH;
        end else begin
          state_d = WR_DVD;
        end
      end
      WR_DVD:   if (ack) state_d = WR_DVS;
      WR_DVS:   if (ack) state_d = WR_START;
      WR_START: begin
        if (ack) begin
          gap_cnt_d = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: begin
        gap_cnt_d = !gap_cnt_q;
        if (gap_cnt_q) state_d = RD_FINI;
      end
      RD_FINI: begin
        if (ack) begin
          if (wbm_dat_i[0]) begin
            state_d = RD_QUO;
          end else begin
            poll_d = poll_q + PCW'(1);
            if (poll_q == POLL_LAST) begin
              quo_d    = '0;
              status_d = STATUS_TIMEOUT;
              state_d  = PUSH;
            end
          end
        end
      end
      RD_QUO: begin
        if (ack) begin
          quo_d    = wbm_dat_i[XLEN-1:0];
          status_d = STATUS_OK;
          state_d  = PUSH;
        end
      end
      PUSH:     if (res_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      status_q  <= '0;
      poll_q    <= '0;
      gap_cnt_q <= 1'b0;
      acked_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      status_q  <= status_d;
      poll_q    <= poll_d;
      gap_cnt_q <= gap_cnt_d;
      acked_q   <= ack;
    end
  end

  assign res_valid_o    = (state_q == PUSH);
  assign res_quotient_o = quo_q;
  assign res_status_o   = status_q;
  assign busy_o         = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_proj_div_sequencer.sv
// Directed bench for proj_div_sequencer with a behavioural Wishbone divider slave.
`timescale 1ns/1ps
module tb_proj_div_sequencer;
  import proj_div_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic        op_valid = 1'b0;
  logic        op_ready_o;
  logic [31:0] op_dividend = '0;
  logic [31:0] op_divisor = '0;
  logic        res_valid_o;
  logic        res_ready = 1'b0;
  logic [31:0] res_quotient_o;
  logic [1:0]  res_status_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '1;
  logic        wbm_ack_i = 1'b0;
  logic        busy_o;
  state_t      dbg_state;

  int vectors = 0;
  int miscompares = 0;

  proj_div_sequencer #(
    .WBW(32), .XLEN(32), .DEPTH(4), .POLL_LIMIT(32)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .op_valid_i     (op_valid),
    .op_ready_o     (op_ready_o),
    .op_dividend_i  (op_dividend),
    .op_divisor_i   (op_divisor),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready),
    .res_quotient_o (res_quotient_o),
    .res_status_o   (res_status_o),
    .wbm_cyc_o      (wbm_cyc_o),
    .wbm_stb_o      (wbm_stb_o),
    .wbm_we_o       (wbm_we_o),
    .wbm_sel_o      (wbm_sel_o),
    .wbm_adr_o      (wbm_adr_o),
    .wbm_dat_o      (wbm_dat_o),
    .wbm_dat_i      (wbm_dat_i),
    .wbm_ack_i      (wbm_ack_i),
    .busy_o         (busy_o),
    .dbg_state_o    (dbg_state)
  );

  // divider slave model, evaluated on the falling edge
  int ack_delay = 0;
  int fini_latency = 0;
  bit fini_never = 1'b0;
  int wait_cnt = 0;
  int fini_pend = 0;
  int fini_reads = 0;
  int cyc_cycles = 0;
  int stable_err = 0;
  int b2b_err = 0;
  int rd_dat_err = 0;
  logic [31:0] m_dvd = '0, m_dvs = '0, m_quo = '0;
  logic [31:0] wr_adr_q[$];
  logic        prev_stb = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(negedge clk) begin
    if (wbm_cyc_o) cyc_cycles++;
    if (wbm_stb_o && wbm_ack_i) b2b_err++;
    if (wbm_stb_o && prev_stb && !wbm_ack_i &&
        (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat || wbm_we_o !== prev_we))
      stable_err++;
    if (wbm_stb_o && !wbm_we_o && wbm_dat_o !== 32'h0) rd_dat_err++;
    if (wbm_stb_o && !wbm_ack_i) begin
      if (wait_cnt >= ack_delay) begin
        wait_cnt  = 0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFF_FFFF;
        if (wbm_we_o) begin
          wr_adr_q.push_back(wbm_adr_o);
          case (wbm_adr_o)
            32'h3000_0000: m_dvd = wbm_dat_o;
            32'h3000_0004: m_dvs = wbm_dat_o;
            32'h3000_0018: begin
              m_quo     = (m_dvs == 0) ? 32'h0 : m_dvd / m_dvs;
              fini_pend = fini_latency;
            end
            default: ;
          endcase
        end else begin
          case (wbm_adr_o)
            32'h3000_0014: begin
              fini_reads++;
              if (fini_never) wbm_dat_i = 32'hFFFF_FFFE;
              else if (fini_pend == 0) wbm_dat_i = 32'h0000_0001;
              else begin
                fini_pend--;
                wbm_dat_i = 32'hFFFF_FFFE;
              end
            end
            32'h3000_0008: wbm_dat_i = m_quo;
            default: ;
          endcase
        end
      end else begin
        wait_cnt++;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hFFFF_FFFF;
      end
    end else begin
      wait_cnt  = 0;
      wbm_ack_i = 1'b0;
      wbm_dat_i = 32'hFFFF_FFFF;
    end
    prev_stb = wbm_stb_o;
    prev_we  = wbm_we_o;
    prev_adr = wbm_adr_o;
    prev_dat = wbm_dat_o;
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_op(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    op_valid    = 1'b1;
    op_dividend = a;
    op_divisor  = b;
    while (!op_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_accepted", 32'(op_ready_o), 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [31:0] eq,
                            input logic [31:0] es, input int limit);
    int n = 0;
    @(negedge clk);
    res_ready = 1'b1;
    while (!res_valid_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(res_valid_o), 32'd1);
    check({tag, "_quo"}, res_quotient_o, eq);
    check({tag, "_status"}, 32'(res_status_o), es);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int n;
    int busy_seen;
    int valid_seen;

    // reset state
    #1 reset_i = 1'b1;
    #2;
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_we", 32'(wbm_we_o), 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_quo", res_quotient_o, 32'd0);
    check("rst_status", 32'(res_status_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_op_ready", 32'(op_ready_o), 32'd1);

    // 100/4 with two not-finished polls
    fini_latency = 2;
    wr_adr_q.delete();
    fini_reads = 0;
    cyc_cycles = 0;
    push_op(32'd100, 32'd4);
    get_result("div100_4", 32'd25, 32'd0, 300);
    check("div100_4_nwrites", 32'(wr_adr_q.size()), 32'd3);
    check("div100_4_wr0", wr_adr_q.pop_front(), 32'h3000_0000);
    check("div100_4_wr1", wr_adr_q.pop_front(), 32'h3000_0004);
    check("div100_4_wr2", wr_adr_q.pop_front(), 32'h3000_0018);
    check("div100_4_fini_reads", 32'(fini_reads), 32'd3);
    check("div100_4_cyc_cycles", 32'(cyc_cycles), 32'd7);

    // bad divisors never touch the bus
    cyc_cycles = 0;
    push_op(32'd7, 32'd1);
    get_result("div7_1", 32'd0, 32'd2, 100);
    push_op(32'd9, 32'd0);
    get_result("div9_0", 32'd0, 32'd2, 100);
    check("bad_dvs_cyc_cycles", 32'(cyc_cycles), 32'd0);

    // odd divisor forwarded as-is
    fini_latency = 0;
    push_op(32'd100, 32'd7);
    get_result("div100_7", 32'd14, 32'd0, 300);
    check("odd_dvs_forwarded", m_dvs, 32'd7);

    // backpressure: result held, FIFO fills to 4
    push_op(32'd20, 32'd2);
    push_op(32'd21, 32'd3);
    push_op(32'd40, 32'd5);
    push_op(32'd9, 32'd1);
    push_op(32'd99, 32'd10);
    repeat (40) @(negedge clk);
    check("bp_op_ready_low", 32'(op_ready_o), 32'd0);
    check("bp_res_valid_held", 32'(res_valid_o), 32'd1);
    check("bp_busy", 32'(busy_o), 32'd1);
    fork
      push_op(32'd64, 32'd8);
    join_none
    get_result("bp0", 32'd10, 32'd0, 300);
    get_result("bp1", 32'd7, 32'd0, 300);
    get_result("bp2", 32'd8, 32'd0, 300);
    get_result("bp3", 32'd0, 32'd2, 300);
    get_result("bp4", 32'd9, 32'd0, 300);
    get_result("bp5", 32'd8, 32'd0, 300);

    // FINI never set: poll budget exhausted
    fini_never = 1'b1;
    fini_reads = 0;
    push_op(32'd50, 32'd5);
    get_result("timeout", 32'd0, 32'd1, 600);
    check("timeout_fini_reads", 32'(fini_reads), 32'd32);
    fini_never = 1'b0;

    // slow slave: 5 wait cycles on every access
    ack_delay    = 5;
    fini_latency = 1;
    stable_err   = 0;
    cyc_cycles   = 0;
    push_op(32'd1000, 32'd8);
    get_result("slow", 32'd125, 32'd0, 600);
    check("slow_stable", 32'(stable_err), 32'd0);
    check("slow_cyc_cycles", 32'(cyc_cycles), 32'd36);
    ack_delay = 0;

    // reset in the middle of polling
    fini_never = 1'b1;
    push_op(32'd30, 32'd3);
    push_op(32'd40, 32'd4);
    n = 0;
    while (!(dbg_state == RD_FINI && wbm_stb_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_in_rd_fini", 32'(dbg_state == RD_FINI && wbm_cyc_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("mid_rst_stb", 32'(wbm_stb_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_adr", wbm_adr_o, 32'd0);
    @(negedge clk);
    reset_i    = 1'b0;
    fini_never = 1'b0;
    res_ready  = 1'b1;
    busy_seen  = 0;
    valid_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_o) busy_seen++;
      if (res_valid_o) valid_seen++;
    end
    res_ready = 1'b0;
    check("post_rst_fifo_empty", 32'(busy_seen), 32'd0);
    check("post_rst_no_result", 32'(valid_seen), 32'd0);
    check("post_rst_op_ready", 32'(op_ready_o), 32'd1);

    // bus protocol checks gathered over the whole run
    check("no_back_to_back", 32'(b2b_err), 32'd0);
    check("read_dat_zero", 32'(rd_dat_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
